// File: rtl/freq_peak_detect.sv
// ============================================================================
// freq_peak_detect
// Scans a 16-bin complex FFT frame two bins per cycle and reports the index and
// squared magnitude of the strongest bin.
// Revision: 1.0
// ============================================================================
`default_nettype none

module freq_peak_detect (
    input  logic        clk,
    input  logic        rst,
    input  logic        fft_valid,
    input  logic [31:0] fft_d0,
    input  logic [31:0] fft_d1,
    input  logic [31:0] fft_d2,
    input  logic [31:0] fft_d3,
    input  logic [31:0] fft_d4,
    input  logic [31:0] fft_d5,
    input  logic [31:0] fft_d6,
    input  logic [31:0] fft_d7,
    input  logic [31:0] fft_d8,
    input  logic [31:0] fft_d9,
    input  logic [31:0] fft_d10,
    input  logic [31:0] fft_d11,
    input  logic [31:0] fft_d12,
    input  logic [31:0] fft_d13,
    input  logic [31:0] fft_d14,
    input  logic [31:0] fft_d15,
    output logic        done,
    output logic [3:0]  freq,
    output logic [31:0] mag_max,
    output logic        busy,
    output logic        ovf
);

    localparam logic [2:0] LAST_PAIR = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  pair_q, pair_d;
    logic        w_capture;
    logic        w_ovf_set;

    logic [31:0] w_bins [16];
    logic [31:0] buf_q  [16];

    logic [31:0] s1_mag_e_q, s1_mag_o_q;
    logic [2:0]  s1_pair_q;
    logic        s1_valid_q;

    logic [31:0] run_mag_q;
    logic [3:0]  run_idx_q;
    logic [31:0] mag_q;
    logic [3:0]  freq_q;
    logic        done_q;
    logic        ovf_q;

    assign w_bins[0]  = fft_d0;
    assign w_bins[1]  = fft_d1;
    assign w_bins[2]  = fft_d2;
    assign w_bins[3]  = fft_d3;
    assign w_bins[4]  = fft_d4;
    assign w_bins[5]  = fft_d5;
    assign w_bins[6]  = fft_d6;
    assign w_bins[7]  = fft_d7;
    assign w_bins[8]  = fft_d8;
    assign w_bins[9]  = fft_d9;
    assign w_bins[10] = fft_d10;
    assign w_bins[11] = fft_d11;
    assign w_bins[12] = fft_d12;
    assign w_bins[13] = fft_d13;
    assign w_bins[14] = fft_d14;
    assign w_bins[15] = fft_d15;

    // Squares are at most 2^30 each, so the 32-bit unsigned sum cannot wrap.
    function automatic logic [31:0] mag2(input logic [31:0] bin);
        logic signed [31:0] re;
        logic signed [31:0] im;
        logic signed [31:0] re_sq;
        logic signed [31:0] im_sq;
        re    = {{16{bin[31]}}, bin[31:16]};
        im    = {{16{bin[15]}}, bin[15:0]};
        re_sq = re * re;
        im_sq = im * im;
        return $unsigned(re_sq) + $unsigned(im_sq);
    endfunction

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pair_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            pair_q  <= pair_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pair_d    = pair_q;
        w_capture = 1'b0;
        w_ovf_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fft_valid) begin
                    w_capture = 1'b1;
                    pair_d    = 3'd0;
                    state_d   = S_SCAN;
                end
            end
            S_SCAN: begin
                w_ovf_set = fft_valid;
                pair_d    = pair_q + 3'd1;
                if (pair_q == LAST_PAIR) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                w_ovf_set = fft_valid;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Frame buffer and stage 1 (squared magnitudes of the current pair)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= 32'd0;
            end
        end else if (w_capture) begin
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= w_bins[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_mag_e_q <= 32'd0;
            s1_mag_o_q <= 32'd0;
            s1_pair_q  <= 3'd0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_mag_e_q <= mag2(buf_q[{pair_q, 1'b0}]);
            s1_mag_o_q <= mag2(buf_q[{pair_q, 1'b1}]);
            s1_pair_q  <= pair_q;
            s1_valid_q <= (state_q == S_SCAN);
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: pair winner vs running max, lowest index wins ties
    // ------------------------------------------------------------------
    logic        w_odd_wins;
    logic [31:0] w_pair_mag;
    logic [3:0]  w_pair_idx;
    logic        w_take_pair;
    logic [31:0] w_new_mag;
    logic [3:0]  w_new_idx;
    logic        w_last;

    always_comb begin
        w_odd_wins  = (s1_mag_o_q > s1_mag_e_q);
        w_pair_mag  = w_odd_wins ? s1_mag_o_q : s1_mag_e_q;
        w_pair_idx  = {s1_pair_q, w_odd_wins};
        w_take_pair = (s1_pair_q == 3'd0) || (w_pair_mag > run_mag_q);
        w_new_mag   = w_take_pair ? w_pair_mag : run_mag_q;
        w_new_idx   = w_take_pair ? w_pair_idx : run_idx_q;
        w_last      = s1_valid_q && (s1_pair_q == LAST_PAIR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_mag_q <= 32'd0;
            run_idx_q <= 4'd0;
            mag_q     <= 32'd0;
            freq_q    <= 4'd0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            done_q <= w_last;
            if (s1_valid_q) begin
                run_mag_q <= w_new_mag;
                run_idx_q <= w_new_idx;
            end
            if (w_last) begin
                mag_q  <= w_new_mag;
                freq_q <= w_new_idx;
            end
            if (w_ovf_set) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign done    = done_q;
    assign freq    = freq_q;
    assign mag_max = mag_q;
    assign busy    = (state_q != S_IDLE);
    assign ovf     = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_freq_peak_detect.sv
// ============================================================================
// tb_freq_peak_detect
// Directed self-checking bench for freq_peak_detect.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_freq_peak_detect;

    logic        clk = 1'b0;
    logic        rst;
    logic        fft_valid;
    logic [31:0] stim [16];
    logic        done;
    logic [3:0]  freq;
    logic [31:0] mag_max;
    logic        busy;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    freq_peak_detect dut (
        .clk      (clk),
        .rst      (rst),
        .fft_valid(fft_valid),
        .fft_d0   (stim[0]),
        .fft_d1   (stim[1]),
        .fft_d2   (stim[2]),
        .fft_d3   (stim[3]),
        .fft_d4   (stim[4]),
        .fft_d5   (stim[5]),
        .fft_d6   (stim[6]),
        .fft_d7   (stim[7]),
        .fft_d8   (stim[8]),
        .fft_d9   (stim[9]),
        .fft_d10  (stim[10]),
        .fft_d11  (stim[11]),
        .fft_d12  (stim[12]),
        .fft_d13  (stim[13]),
        .fft_d14  (stim[14]),
        .fft_d15  (stim[15]),
        .done     (done),
        .freq     (freq),
        .mag_max  (mag_max),
        .busy     (busy),
        .ovf      (ovf)
    );

    task automatic fill_stim(input logic [31:0] v);
        for (int i = 0; i < 16; i++) stim[i] = v;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        fft_valid = 1'b0;
        fill_stim(32'd0);
        repeat (2) @(negedge clk);
        checks++;
        if ({done, freq, mag_max, busy, ovf} !== 39'd0) begin
            failures++;
            $display("FAIL reset_held done=%b freq=%0d mag=%0d busy=%b ovf=%b expected all zero",
                     done, freq, mag_max, busy, ovf);
        end
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if ({done, freq, mag_max, busy, ovf} !== 39'd0) begin
                failures++;
                $display("FAIL reset_idle c=%0d done=%b freq=%0d mag=%0d busy=%b ovf=%b expected all zero",
                         c, done, freq, mag_max, busy, ovf);
            end
        end
    endtask

    task automatic test_single_peak();
        fill_stim(32'd0);
        stim[5] = 32'h0100_0000;
        @(negedge clk);
        fft_valid = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            fft_valid = 1'b0;
            checks++;
            if (busy !== (c <= 9)) begin
                failures++;
                $display("FAIL single_busy c=%0d got=%b expected=%b", c, busy, (c <= 9));
            end
            checks++;
            if (done !== (c == 10)) begin
                failures++;
                $display("FAIL single_done c=%0d got=%b expected=%b", c, done, (c == 10));
            end
            if (c < 10) begin
                checks++;
                if (freq !== 4'd0 || mag_max !== 32'd0) begin
                    failures++;
                    $display("FAIL single_hold_early c=%0d freq=%0d mag=%0d expected 0/0", c, freq, mag_max);
                end
            end else begin
                checks++;
                if (freq !== 4'd5 || mag_max !== 32'd65536) begin
                    failures++;
                    $display("FAIL single_result c=%0d freq=%0d mag=%0d expected 5/65536", c, freq, mag_max);
                end
            end
        end
    endtask

    task automatic test_tie_sign();
        fill_stim(32'd0);
        stim[3]  = 32'hFF00_0000;
        stim[12] = 32'h0000_0100;
        @(negedge clk);
        fft_valid = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            fft_valid = 1'b0;
            if (c == 9) begin
                checks++;
                if (freq !== 4'd5) begin
                    failures++;
                    $display("FAIL tie_prev_hold freq=%0d expected=5", freq);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || freq !== 4'd3 || mag_max !== 32'd65536) begin
            failures++;
            $display("FAIL tie_result done=%b freq=%0d mag=%0d expected 1/3/65536", done, freq, mag_max);
        end
    endtask

    task automatic test_extremes();
        fill_stim(32'd1);
        stim[15] = 32'h8000_8000;
        @(negedge clk);
        fft_valid = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            fft_valid = 1'b0;
        end
        checks++;
        if (done !== 1'b1 || freq !== 4'd15 || mag_max !== 32'h8000_0000) begin
            failures++;
            $display("FAIL extremes done=%b freq=%0d mag=%h expected 1/15/80000000", done, freq, mag_max);
        end
    endtask

    // Frames at cycles 0, 16 and 26; the last one lands on the done cycle.
    task automatic test_back_to_back();
        logic [3:0]  exp_f;
        logic [31:0] exp_m;
        fill_stim(32'd0);
        stim[2] = 32'h0010_0000;
        @(negedge clk);
        fft_valid = 1'b1;
        for (int c = 1; c <= 37; c++) begin
            @(negedge clk);
            fft_valid = 1'b0;
            checks++;
            if (done !== (c == 10 || c == 26 || c == 36)) begin
                failures++;
                $display("FAIL b2b_done c=%0d got=%b", c, done);
            end
            if (c == 10 || c == 26 || c == 36) begin
                exp_f = (c == 10) ? 4'd2 : (c == 26) ? 4'd9 : 4'd11;
                exp_m = (c == 10) ? 32'd256 : (c == 26) ? 32'd1024 : 32'd9;
                checks++;
                if (freq !== exp_f || mag_max !== exp_m || ovf !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_result c=%0d freq=%0d mag=%0d ovf=%b expected %0d/%0d/0",
                             c, freq, mag_max, ovf, exp_f, exp_m);
                end
            end
            if (c == 16) begin
                fill_stim(32'd0);
                stim[9] = 32'h0000_0020;
                fft_valid = 1'b1;
            end
            if (c == 26) begin
                fill_stim(32'd0);
                stim[11] = 32'hFFFD_0000;
                fft_valid = 1'b1;
            end
        end
    endtask

    task automatic test_overflow();
        fill_stim(32'd0);
        stim[2] = 32'h0010_0000;
        @(negedge clk);
        fft_valid = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            fft_valid = 1'b0;
            checks++;
            if (ovf !== (c >= 5)) begin
                failures++;
                $display("FAIL ovf_flag c=%0d got=%b expected=%b", c, ovf, (c >= 5));
            end
            if (c == 4) begin
                fill_stim(32'd0);
                stim[7] = 32'h7FFF_0000;
                fft_valid = 1'b1;
            end
            if (c == 10) begin
                checks++;
                if (done !== 1'b1 || freq !== 4'd2 || mag_max !== 32'd256) begin
                    failures++;
                    $display("FAIL ovf_result done=%b freq=%0d mag=%0d expected 1/2/256", done, freq, mag_max);
                end
            end
            if (c == 11) begin
                checks++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    failures++;
                    $display("FAIL ovf_dropped busy=%b done=%b expected 0/0", busy, done);
                end
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        fill_stim(32'd0);
        stim[4] = 32'h0000_0040;
        @(negedge clk);
        fft_valid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            fft_valid = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({done, freq, mag_max, busy, ovf} !== 39'd0) begin
            failures++;
            $display("FAIL midreset_now done=%b freq=%0d mag=%0d busy=%b ovf=%b expected all zero",
                     done, freq, mag_max, busy, ovf);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL midreset_quiet c=%0d done=%b busy=%b expected 0/0", c, done, busy);
            end
        end
        fill_stim(32'd0);
        stim[6] = 32'h0002_0003;
        fft_valid = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            fft_valid = 1'b0;
        end
        checks++;
        if (done !== 1'b1 || freq !== 4'd6 || mag_max !== 32'd13) begin
            failures++;
            $display("FAIL midreset_after done=%b freq=%0d mag=%0d expected 1/6/13", done, freq, mag_max);
        end
    endtask

    task automatic test_all_zero();
        fill_stim(32'd0);
        @(negedge clk);
        fft_valid = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            fft_valid = 1'b0;
        end
        checks++;
        if (done !== 1'b1 || freq !== 4'd0 || mag_max !== 32'd0) begin
            failures++;
            $display("FAIL all_zero done=%b freq=%0d mag=%0d expected 1/0/0", done, freq, mag_max);
        end
    endtask

    initial begin
        test_reset();
        test_single_peak();
        test_tie_sign();
        test_extremes();
        test_back_to_back();
        test_overflow();
        test_reset_mid_scan();
        test_all_zero();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
